// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM port arbiter: controller states,
// requester id and the read-tag carried alongside each macro access.
package sram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef logic id_t;

    typedef struct packed {
        logic rd;
        id_t  id;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid always wins, a tie goes to the
// requester that did not win last time.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  id_t                last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Sole driver of an OpenRAM port 0: zero-fills the array after reset, then
// shares the port between two requesters and returns reads two cycles later.
//
// state | meaning
// INIT  | writing zero to addr init_cnt each cycle; requesters held off
// RUN   | one granted request per cycle issued to the macro
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk0,
    input  logic                          rst0,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_done,
    output logic                          csb0,
    output logic                          web0,
    output logic [ADDR_WIDTH-1:0]         addr0,
    output logic [DATA_WIDTH-1:0]         din0,
    input  logic [DATA_WIDTH-1:0]         dout0
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    id_t                     last_grant;
    logic [NUM_REQ-1:0]      grant;
    tag_t                    tag_s1;
    tag_t                    tag_s2;

    id_t                     gid;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is the grant itself, so a handshake happens exactly where ready is set.
    assign req_ready = (state == RUN) ? grant : '0;
    assign gid       = id_t'(grant[1]);
    assign sel_we    = req_we[gid];
    assign sel_addr  = req_addr[int'(gid)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(gid)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state      <= INIT;
            init_cnt   <= '0;
            init_done  <= 1'b0;
            last_grant <= 1'b1;
            csb0       <= 1'b1;
            web0       <= 1'b1;
            addr0      <= '0;
            din0       <= '0;
            tag_s1     <= '0;
            tag_s2     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            tag_s1    <= '0;
            tag_s2    <= tag_s1;
            rsp_valid <= '0;
            // dout0 settled in the low phase after the macro sampled the read.
            if (tag_s2.rd) begin
                rsp_valid[tag_s2.id] <= 1'b1;
                rsp_rdata            <= dout0;
            end

            case (state)
                INIT: begin
                    csb0     <= 1'b0;
                    web0     <= 1'b0;
                    addr0    <= init_cnt;
                    din0     <= '0;
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (|req_ready) begin
                        csb0       <= 1'b0;
                        web0       <= ~sel_we;
                        addr0      <= sel_addr;
                        din0       <= sel_wdata;
                        last_grant <= gid;
                        tag_s1     <= '{rd: ~sel_we, id: gid};
                    end else begin
                        csb0 <= 1'b1;
                        web0 <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural OpenRAM port model, vector table
// for arbitration, and a read scoreboard keyed on the expected response cycle.
module tb_sram_port_arbiter;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_we;
    logic [7:0] req_addr;
    logic [3:0] req_wdata;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_rdata;
    logic       init_done;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [1:0] din0;
    logic [1:0] dout0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk0 = ~clk0;

    sram_port_arbiter #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    // Macro model: inputs registered on posedge, array access in the low phase.
    logic [1:0] mem [16];
    logic       m_csb = 1'b1;
    logic       m_web = 1'b1;
    logic [3:0] m_addr;
    logic [1:0] m_din;

    initial for (int i = 0; i < 16; i++) mem[i] = 2'b11;

    always @(posedge clk0) begin
        m_csb  <= csb0;
        m_web  <= web0;
        m_addr <= addr0;
        m_din  <= din0;
        cyc    <= cyc + 1;
    end

    always @(negedge clk0) begin
        if (!m_csb) begin
            if (!m_web) mem[m_addr] = m_din;
            else        dout0 <= mem[m_addr];
        end
    end

    // Scoreboard: reads pushed at handshake, popped at the due cycle.
    typedef struct {
        int         id;
        logic [1:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] ref_mem [16];

    always @(negedge clk0) begin
        exp_t e;
        if (rst0) begin
            sb.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = 2'b00;
        end else begin
            if (rsp_valid != 2'b00) begin
                checks++;
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    failures++;
                    $display("FAIL rsp_unexpected rsp_valid=%b at cyc %0d, none required", rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid != 2'(1 << e.id) || rsp_rdata != e.data) begin
                        failures++;
                        $display("FAIL rsp_data rsp_valid=%b rdata=%b, required valid=%b rdata=%b at cyc %0d",
                                 rsp_valid, rsp_rdata, 2'(1 << e.id), e.data, cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                failures++;
                e = sb.pop_front();
                $display("FAIL rsp_missing rsp_valid=00, required id %0d data %b at cyc %0d", e.id, e.data, e.due);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_we[i]) ref_mem[req_addr[i*4 +: 4]] = req_wdata[i*2 +: 2];
                    else sb.push_back('{id: i, data: ref_mem[req_addr[i*4 +: 4]], due: cyc + 3});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [1:0] d0, input logic [1:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic chk_reset_values();
        chk("rst_csb0", csb0, 1);
        chk("rst_web0", web0, 1);
        chk("rst_addr0", addr0, 0);
        chk("rst_din0", din0, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_init_done", init_done, 0);
    endtask

    task automatic run_init();
        for (int k = 0; k < 16; k++) begin
            chk("init_ready", req_ready, 0);
            tick();
            chk("init_csb0", csb0, 0);
            chk("init_web0", web0, 0);
            chk("init_addr0", addr0, k);
            chk("init_din0", din0, 0);
            chk("init_done", init_done, (k == 15) ? 1 : 0);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [1:0] d0;
        logic [1:0] d1;
        logic [1:0] ready;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // last_grant = 0 entering the table (previous grants all to requester 0)
        vecs[0]  = '{2'b01, 2'b01, 4'd5,  4'd0, 2'b10, 2'b00, 2'b01};
        vecs[1]  = '{2'b01, 2'b00, 4'd5,  4'd0, 2'b00, 2'b00, 2'b01};
        vecs[2]  = '{2'b10, 2'b10, 4'd0,  4'd1, 2'b00, 2'b01, 2'b10};
        vecs[3]  = '{2'b01, 2'b01, 4'd2,  4'd0, 2'b10, 2'b00, 2'b01};
        vecs[4]  = '{2'b10, 2'b10, 4'd0,  4'd15, 2'b00, 2'b11, 2'b10};
        vecs[5]  = '{2'b01, 2'b00, 4'd15, 4'd0, 2'b00, 2'b00, 2'b01};
        vecs[6]  = '{2'b10, 2'b00, 4'd0,  4'd3, 2'b00, 2'b00, 2'b10};
        vecs[7]  = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b01};
        vecs[8]  = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b10};
        vecs[9]  = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b01};
        vecs[10] = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b10};
        vecs[11] = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b01};
        vecs[12] = '{2'b11, 2'b00, 4'd1,  4'd2, 2'b00, 2'b00, 2'b10};
        vecs[13] = '{2'b00, 2'b00, 4'd0,  4'd0, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{2'b11, 2'b11, 4'd4,  4'd4, 2'b01, 2'b11, 2'b01};
        vecs[15] = '{2'b11, 2'b11, 4'd4,  4'd4, 2'b01, 2'b11, 2'b10};
        vecs[16] = '{2'b01, 2'b00, 4'd4,  4'd0, 2'b00, 2'b00, 2'b01};

        // Reset with both requesters already asking; nothing may be accepted in INIT.
        rst0 = 1'b1;
        drive(2'b11, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
        tick();
        tick();
        chk_reset_values();
        rst0 = 1'b0;
        run_init();
        #1;
        chk("first_grant", req_ready, 2'b01);
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(2'b01, 2'b00, 4'(i), 4'd0, 2'b00, 2'b00);
            #1;
            chk("readback_ready", req_ready, 2'b01);
            tick();
        end

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].ready);
            tick();
        end

        // Idle: macro deselected, address held from the last access.
        drive(2'b00, 2'b00, 4'd9, 4'd9, 2'b00, 2'b00);
        tick();
        chk("idle_csb0", csb0, 1);
        chk("idle_web0", web0, 1);
        chk("idle_addr0", addr0, 4);
        tick();
        tick();

        // Two reads in flight when reset hits: both must vanish.
        drive(2'b01, 2'b00, 4'd5, 4'd0, 2'b00, 2'b00);
        tick();
        drive(2'b01, 2'b00, 4'd4, 4'd0, 2'b00, 2'b00);
        tick();
        drive(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
        rst0 = 1'b1;
        tick();
        chk_reset_values();
        rst0 = 1'b0;
        tick();
        chk("reinit_done_low", init_done, 0);
        chk("reinit_rsp_valid", rsp_valid, 0);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        run_init();

        drive(2'b10, 2'b00, 4'd0, 4'd5, 2'b00, 2'b00);
        #1;
        chk("post_reset_ready", req_ready, 2'b10);
        tick();
        drive(2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin controller that shares the single read/write port of an OpenRAM SRAM macro (csb0/web0/addr0/din0/dout0, active-low controls, inputs registered on posedge) between two requesters. After every reset it zero-fills the whole array, then grants one request per cycle and returns read data with a fixed latency. It sits directly in front of the macro and is the only driver of the macro's port-0 inputs.

## Interface
- DATA_WIDTH, 2, word width; must match the macro.
- ADDR_WIDTH, 4, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- clk0  in  1  clock, shared with the macro.
- rst0  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a handshake occurs when valid and ready are both high at a posedge.
- req_we  in  2  per-requester write enable: 1 = write, 0 = read.
- req_addr  in  2×ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2×DATA_WIDTH  per-requester write data, sliced the same way.
- rsp_valid  out  2  one-cycle read-response pulse per requester.
- rsp_rdata  out  DATA_WIDTH  read data; meaningful only while a rsp_valid bit is high.
- init_done  out  1  high once the zero-fill has completed.
- csb0, web0  out  1 each  to the macro; active-low.
- addr0  out  ADDR_WIDTH  to the macro.
- din0  out  DATA_WIDTH  to the macro.
- dout0  in  DATA_WIDTH  from the macro.

## Operation
- States: INIT and RUN. Reset forces INIT with init_cnt = 0.
- INIT:
  - Every cycle, register csb0 = 0, web0 = 0, addr0 = init_cnt, din0 = 0, then increment init_cnt.
  - At init_cnt = RAM_DEPTH-1, go to RUN and set init_done = 1.
  - req_ready stays 00 throughout.
- RUN, arbitration:
  - last_grant resets to 1, so requester 0 wins the first contention.
  - One valid only: that requester is granted.
  - Both valid: grant !last_grant.
  - last_grant updates on every grant.
  - req_ready = grant one-hot, gated by RUN. Ready depends combinationally on req_valid; no ready-to-valid loop is permitted upstream.
- Issue on handshake: register csb0 = 0, web0 = !req_we, addr0, din0 from the granted slice.
- Idle cycle: register csb0 = 1 and web0 = 1; addr0 and din0 hold their values.
- Reads:
  - A two-stage tag pipe carries {read, id}.
  - At stage 2, capture dout0 into rsp_rdata and pulse rsp_valid[id].
  - Responses have no backpressure.
  - Writes produce no response.
- Reset mid-operation:
  - In-flight reads are dropped; no rsp_valid is issued for them.
  - Control returns to INIT and the array is zero-filled again.
- Reset values:
  - csb0 = 1, web0 = 1.
  - addr0, din0 and rsp_rdata = 0.
  - req_ready, rsp_valid and init_done = 0.

## Timing
- Handshake at edge t: the macro command is registered at t, the macro samples it at t+1, and array access completes in the following low phase.
- Read latency: rsp_valid is high in the cycle after edge t+2, i.e. 2 cycles after accept.
- Throughput: one access per cycle, sustained.
- Back-to-back write then read of the same address returns the new data; the macro's ordering guarantees this.
- Zero-fill takes RAM_DEPTH cycles. init_done rises at the edge that registers the last init write. The first request can be accepted in the first RUN cycle.
- Requirement on the clock: half period > macro DELAY, so dout0 is stable at the capture edge.

## Structure
- Package sram_arb_pkg holds:
  - the state enum {INIT, RUN};
  - the requester-id type (1 bit);
  - NUM_REQ = 2;
  - the tag struct {rd, id}.
- Sub-module rr_arb2 is pure two-way round-robin logic: it takes valid[1:0] and last_grant, and produces the grant one-hot.
- Counter, command registers and tag pipe live in the top module.

## Test plan
- **Reset then init:** release rst0 and monitor the macro port → 16 writes of 0 to addr 0..15 on consecutive cycles, with init_done rising after the 16th. Then read every address → all return 2'b00.
- **Write then read, single requester:** requester 0 writes addr 5 = 2'b10, then reads addr 5 on the next cycle → rsp_valid[0] 2 cycles after the read accept, rsp_rdata = 2'b10, rsp_valid[1] never high.
- **Sustained contention:** both requesters valid for 6 cycles, reading addr 1 (holding 01) and addr 2 (holding 10) → grants alternate 0,1,0,1,0,1 and responses alternate 01/10 with the matching ids.
- **Back-to-back RAW across requesters:** requester 1 writes addr 15 = 11, then requester 0 reads addr 15 next cycle → rdata = 11.
- **Reset during reads:** issue 2 reads, assert rst0 one cycle later → no rsp_valid; zero-fill restarts and init_done = 0 until it completes.
- **Valid during INIT:** hold req_valid = 11 during init → req_ready = 00, and the first grant goes to requester 0 in the first RUN cycle.
